// File: rtl/fpga_top_calc_pkg.sv
// rtl/fpga_top_calc_pkg.sv - shared op encodings and seven-segment font for the calculator demo
package fpga_top_calc_pkg;

    localparam logic [2:0] OP_PASS_A = 3'd0;
    localparam logic [2:0] OP_PASS_B = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_SUB    = 3'd3;
    localparam logic [2:0] OP_AND    = 3'd4;
    localparam logic [2:0] OP_OR     = 3'd5;
    localparam logic [2:0] OP_XOR    = 3'd6;
    localparam logic [2:0] OP_SHL    = 3'd7;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;
    localparam logic [7:0] SEG_ONE   = 8'hF9;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fpga_top_calc_seg_scan.sv
// rtl/fpga_top_calc_seg_scan.sv - shared digit scan driving the low and high half-word displays
module fpga_top_calc_seg_scan
    import fpga_top_calc_pkg::*;
#(
    parameter int SCAN_DIV = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    output logic [7:0]  seg_lo,
    output logic [7:0]  seg_hi,
    output logic [3:0]  sel
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [3:0]    nib_lo;
    logic [3:0]    nib_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sel <= 4'b0001;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            sel <= {sel[2:0], sel[3]};
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Both halves share the select, so digit k of each tube shows nibble k of its half-word.
    always_comb begin
        nib_lo = 4'h0;
        nib_hi = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) begin
                nib_lo = data[4*k +: 4];
                nib_hi = data[16 + 4*k +: 4];
            end
        end
    end

    assign seg_lo = hex_to_seg(nib_lo);
    assign seg_hi = hex_to_seg(nib_hi);

endmodule

// File: rtl/fpga_top_calc.sv
// rtl/fpga_top_calc.sv - board top: DIP-switch operands, key-selected ALU, LED and tube output
module fpga_top_calc
    import fpga_top_calc_pkg::*;
#(
    parameter int SCAN_DIV = 4096
) (
    input  logic       clk_in,
    input  logic       sys_rstn,
    input  logic [7:0] dip_switch0,
    input  logic [7:0] dip_switch1,
    input  logic [7:0] dip_switch2,
    input  logic [7:0] dip_switch3,
    input  logic [7:0] dip_switch4,
    input  logic [7:0] dip_switch5,
    input  logic [7:0] dip_switch6,
    input  logic [7:0] dip_switch7,
    input  logic [7:0] user_key,
    output logic [31:0] led_light,
    output logic [7:0] digital_tube0,
    output logic [3:0] digital_tube_sel0,
    output logic [7:0] digital_tube1,
    output logic [3:0] digital_tube_sel1,
    output logic [7:0] digital_tube2,
    output logic       digital_tube_sel2,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [7:0]  key_r;
    logic [31:0] result;
    logic        flag;
    logic [2:0]  op;
    logic [31:0] alu_res;
    logic        alu_flag;
    logic [32:0] sum;
    logic [3:0]  scan_sel;
    logic        unused_rxd;

    always_ff @(posedge clk_in or posedge sys_rstn) begin
        if (sys_rstn) begin
            a_r   <= '0;
            b_r   <= '0;
            key_r <= '0;
        end else begin
            a_r   <= ~{dip_switch3, dip_switch2, dip_switch1, dip_switch0};
            b_r   <= ~{dip_switch7, dip_switch6, dip_switch5, dip_switch4};
            key_r <= ~user_key;
        end
    end

    // Descending scan so the lowest pressed key is the one left standing.
    always_comb begin
        op = OP_PASS_A;
        for (int i = 7; i >= 0; i--) begin
            if (key_r[i]) op = 3'(i);
        end
    end

    assign sum = {1'b0, a_r} + {1'b0, b_r};

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (op)
            OP_PASS_A: alu_res = a_r;
            OP_PASS_B: alu_res = b_r;
            OP_ADD: begin
                alu_res  = sum[31:0];
                alu_flag = sum[32];
            end
            OP_SUB: begin
                alu_res  = a_r - b_r;
                alu_flag = (a_r < b_r);
            end
            OP_AND:    alu_res = a_r & b_r;
            OP_OR:     alu_res = a_r | b_r;
            OP_XOR:    alu_res = a_r ^ b_r;
            OP_SHL:    alu_res = a_r << b_r[4:0];
            default:   alu_res = '0;
        endcase
    end

    always_ff @(posedge clk_in or posedge sys_rstn) begin
        if (sys_rstn) begin
            result <= '0;
            flag   <= 1'b0;
        end else if (|key_r) begin
            result <= alu_res;
            flag   <= alu_flag;
        end
    end

    fpga_top_calc_seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk    (clk_in),
        .rst    (sys_rstn),
        .data   (result),
        .seg_lo (digital_tube0),
        .seg_hi (digital_tube1),
        .sel    (scan_sel)
    );

    assign led_light         = ~result;
    assign digital_tube_sel0 = scan_sel;
    assign digital_tube_sel1 = scan_sel;
    assign digital_tube2     = flag ? SEG_ONE : SEG_ZERO;
    assign digital_tube_sel2 = 1'b1;
    assign uart_txd          = 1'b1;
    assign unused_rxd        = uart_rxd;

endmodule

// File: tb/tb_fpga_top_calc.sv
// tb/tb_fpga_top_calc.sv - randomized and directed self-checking bench for fpga_top_calc
module tb_fpga_top_calc;

    localparam int SD = 4;

    logic        clk_in = 1'b0;
    logic        sys_rstn = 1'b1;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [7:0]  user_key = 8'hFF;
    logic        uart_rxd = 1'b1;
    logic [31:0] led_light;
    logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
    logic [3:0]  digital_tube_sel0, digital_tube_sel1;
    logic        digital_tube_sel2, uart_txd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    fpga_top_calc #(.SCAN_DIV(SD)) dut (
        .clk_in            (clk_in),
        .sys_rstn          (sys_rstn),
        .dip_switch0       (~a_in[7:0]),
        .dip_switch1       (~a_in[15:8]),
        .dip_switch2       (~a_in[23:16]),
        .dip_switch3       (~a_in[31:24]),
        .dip_switch4       (~b_in[7:0]),
        .dip_switch5       (~b_in[15:8]),
        .dip_switch6       (~b_in[23:16]),
        .dip_switch7       (~b_in[31:24]),
        .user_key          (user_key),
        .led_light         (led_light),
        .digital_tube0     (digital_tube0),
        .digital_tube_sel0 (digital_tube_sel0),
        .digital_tube1     (digital_tube1),
        .digital_tube_sel1 (digital_tube_sel1),
        .digital_tube2     (digital_tube2),
        .digital_tube_sel2 (digital_tube_sel2),
        .uart_rxd          (uart_rxd),
        .uart_txd          (uart_txd)
    );

    always #20 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the calculator should hold, given the inputs seen one edge ago.
    function automatic void calc(input logic [31:0] a, input logic [31:0] b, input logic [7:0] pressed,
                                 output logic [31:0] r, output logic f);
        int idx = 8;
        logic [32:0] wide;
        for (int i = 7; i >= 0; i--) if (pressed[i]) idx = i;
        f = 1'b0;
        case (idx)
            0: r = a;
            1: r = b;
            2: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; f = wide[32]; end
            3: begin r = a - b; f = (a < b); end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = a << b[4:0];
        endcase
    endfunction

    int unsigned m_cyc = 0;
    logic [31:0] m_res = '0;
    logic        m_flag = 1'b0;
    logic [31:0] s1_a = '0, s1_b = '0;
    logic [7:0]  s1_pressed = '0;

    always @(posedge clk_in or posedge sys_rstn) begin
        if (sys_rstn) begin
            m_cyc = 0; m_res = '0; m_flag = 1'b0;
            s1_a = '0; s1_b = '0; s1_pressed = '0;
        end else begin
            if (s1_pressed != 8'h00) calc(s1_a, s1_b, s1_pressed, m_res, m_flag);
            s1_a = a_in; s1_b = b_in; s1_pressed = ~user_key;
            m_cyc++;
        end
    end

    always @(negedge clk_in) begin
        int d;
        logic [15:0] lo, hi;
        d  = (m_cyc / SD) % 4;
        lo = m_res[15:0];
        hi = m_res[31:16];
        chk("led", led_light, ~m_res);
        chk("sel0", 32'(digital_tube_sel0), 32'(4'b0001 << d));
        chk("sel1", 32'(digital_tube_sel1), 32'(4'b0001 << d));
        chk("tube0", 32'(digital_tube0), 32'(font[(lo >> (4*d)) & 16'hF]));
        chk("tube1", 32'(digital_tube1), 32'(font[(hi >> (4*d)) & 16'hF]));
        chk("tube2", 32'(digital_tube2), m_flag ? 32'hF9 : 32'hC0);
        chk("sel2", 32'(digital_tube_sel2), 32'd1);
        chk("txd", 32'(uart_txd), 32'd1);
    end

    task automatic wait_sel(input logic [3:0] want);
        int n = 0;
        while (digital_tube_sel0 !== want && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        chk("sel_reach", 32'(digital_tube_sel0), 32'(want));
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [7:0] k);
        a_in = a; b_in = b; user_key = k;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        chk("rst_led", led_light, 32'hFFFF_FFFF);
        chk("rst_tube0", 32'(digital_tube0), 32'hC0);
        chk("rst_tube1", 32'(digital_tube1), 32'hC0);
        chk("rst_tube2", 32'(digital_tube2), 32'hC0);
        chk("rst_sel0", 32'(digital_tube_sel0), 32'h1);
        chk("rst_sel1", 32'(digital_tube_sel1), 32'h1);
        chk("rst_txd", 32'(uart_txd), 32'h1);
        @(posedge clk_in); #1 sys_rstn = 1'b0;

        apply(432, 234, 8'hFB);
        settle();
        chk("add_model", m_res, 32'h29A);
        chk("add_led", led_light, 32'hFFFF_FD65);
        wait_sel(4'b0001); chk("add_d0", 32'(digital_tube0), 32'h88);
        wait_sel(4'b0010); chk("add_d1", 32'(digital_tube0), 32'h90);
        wait_sel(4'b0100); chk("add_d2", 32'(digital_tube0), 32'hA4);
        wait_sel(4'b1000); chk("add_d3", 32'(digital_tube0), 32'hC0);
        chk("add_hi", 32'(digital_tube1), 32'hC0);
        chk("add_flag", 32'(digital_tube2), 32'hC0);

        @(posedge clk_in); #1 apply(432, 234, 8'hF7);
        settle();
        chk("sub_led", led_light, 32'hFFFF_FF39);
        wait_sel(4'b0001); chk("sub_d0", 32'(digital_tube0), 32'h82);
        wait_sel(4'b0010); chk("sub_d1", 32'(digital_tube0), 32'hC6);
        chk("sub_flag", 32'(digital_tube2), 32'hC0);
        @(posedge clk_in); #1 apply(1, 2, 8'hF7);
        settle();
        chk("borrow_led", led_light, 32'h0);
        chk("borrow_flag", 32'(digital_tube2), 32'hF9);

        @(posedge clk_in); #1 apply(32'hFFFF_FFFF, 1, 8'hFB);
        settle();
        chk("carry_led", led_light, 32'hFFFF_FFFF);
        chk("carry_flag", 32'(digital_tube2), 32'hF9);
        @(posedge clk_in); #1 apply(7, 9, 8'hFF);
        settle();
        chk("hold_led", led_light, 32'hFFFF_FFFF);
        chk("hold_flag", 32'(digital_tube2), 32'hF9);

        @(posedge clk_in); #1 apply(5, 3, 8'hF0);
        settle();
        chk("prio_led", led_light, ~32'd5);
        chk("prio_flag", 32'(digital_tube2), 32'hC0);

        wait_sel(4'b0100);
        #5 sys_rstn = 1'b1;
        #1;
        chk("arst_sel0", 32'(digital_tube_sel0), 32'h1);
        chk("arst_led", led_light, 32'hFFFF_FFFF);
        @(posedge clk_in); #1 sys_rstn = 1'b0;
        settle();
        chk("post_rst_led", led_light, ~32'd5);

        for (int c = 0; c < 600; c++) begin
            @(posedge clk_in); #1;
            if (sys_rstn) sys_rstn = 1'b0;
            else if ($urandom_range(0, 59) == 0) sys_rstn = 1'b1;
            a_in = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            b_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            case ($urandom_range(0, 5))
                0:       user_key = 8'hFF;
                1:       user_key = 8'($urandom);
                default: user_key = ~(8'h01 << $urandom_range(0, 7));
            endcase
        end
        sys_rstn = 1'b0;
        repeat (4) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
